// File: rtl/acc_sched_pkg.sv
// Shared constants and state encoding for the accumulator write scheduler.
package acc_sched_pkg;

  localparam int DEPTH      = 8;
  localparam int ADDR_W     = $clog2(DEPTH);
  localparam int NUM_PASS_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRELOAD = 2'd1,
    ACCUM   = 2'd2,
    DRAIN   = 2'd3
  } state_e;

endpackage

// File: rtl/acc_write_scheduler_mod_counter.sv
// Mod-DEPTH up-counter with synchronous clear and a combinational wrap pulse
// that fires in the cycle whose increment takes the count from DEPTH-1 to 0.
module mod_counter #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  assign wrap = inc && (cnt_q == W'(DEPTH - 1));
  assign cnt  = cnt_q;

  // Next count: clear wins over increment; increment wraps at DEPTH-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acc_write_scheduler.sv
// Sequences the CACC (preload) and ACC (accumulate) write ports of an
// 8-entry partial-sum accumulator for one output tile. An address is only
// accumulated once its preload has been written, and the two ports never
// target the same address in the same cycle.
module acc_write_scheduler
  import acc_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_PASS_W-1:0] num_pass,
  input  logic                  comp_valid,
  input  logic                  psum_valid,
  output logic                  CACC_Wr_en,
  output logic [ADDR_W-1:0]     CAcc_Wr_Addr,
  output logic                  ACC_Wr_en,
  output logic [ADDR_W-1:0]     Acc_Wr_Addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_e                  state_q, state_d;
  logic [NUM_PASS_W-1:0]   num_pass_q, num_pass_d;
  logic [NUM_PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    cacc_en_q, cacc_en_d;
  logic [ADDR_W-1:0]       cacc_addr_q, cacc_addr_d;
  logic                    acc_en_q, acc_en_d;
  logic [ADDR_W-1:0]       acc_addr_q, acc_addr_d;

  logic [ADDR_W:0]         pre_cnt;
  logic [ADDR_W:0]         acc_cnt;
  logic                    pre_wrap;
  logic                    acc_wrap;
  logic                    cnt_clr;
  logic                    pre_inc;
  logic                    acc_ok;
  logic                    acc_inc;

  // Counter controls are kept outside the FSM block so the wrap pulses
  // (which depend on inc) do not feed back into the block that drives inc.
  // In PRELOAD an accumulate is legal only for rows whose preload already
  // landed, i.e. strictly below pre_cnt; this also keeps the ports disjoint.
  assign cnt_clr = (state_q == IDLE) && start;
  assign pre_inc = (state_q == PRELOAD) && comp_valid;
  assign acc_ok  = ((state_q == PRELOAD) && (acc_cnt < pre_cnt)) ||
                   (state_q == ACCUM);
  assign acc_inc = psum_valid && acc_ok;

  mod_counter #(.DEPTH(DEPTH), .W(ADDR_W + 1)) u_pre_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (pre_inc),
    .cnt   (pre_cnt),
    .wrap  (pre_wrap)
  );

  mod_counter #(.DEPTH(DEPTH), .W(ADDR_W + 1)) u_acc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (acc_inc),
    .cnt   (acc_cnt),
    .wrap  (acc_wrap)
  );

  // Next-state and next-output logic; all outputs leave through flops.
  always_comb begin
    state_d     = state_q;
    num_pass_d  = num_pass_q;
    pass_cnt_d  = pass_cnt_q;
    err_d       = err_q;
    done_d      = 1'b0;
    cacc_en_d   = 1'b0;
    cacc_addr_d = '0;
    acc_en_d    = 1'b0;
    acc_addr_d  = '0;

    unique case (state_q)
      IDLE: begin
        // Valids while idle are simply dropped.
        if (start) begin
          num_pass_d = (num_pass == '0) ? NUM_PASS_W'(1) : num_pass;
          pass_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = PRELOAD;
        end
      end
      PRELOAD: begin
        if (comp_valid) begin
          cacc_en_d   = 1'b1;
          cacc_addr_d = pre_cnt[ADDR_W-1:0];
          if (pre_wrap) begin
            state_d = ACCUM;
          end
        end
        if (psum_valid) begin
          if (acc_ok) begin
            acc_en_d   = 1'b1;
            acc_addr_d = acc_cnt[ADDR_W-1:0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (comp_valid) begin
          err_d = 1'b1;
        end
        if (psum_valid) begin
          acc_en_d   = 1'b1;
          acc_addr_d = acc_cnt[ADDR_W-1:0];
          if (acc_wrap) begin
            pass_cnt_d = pass_cnt_q + 1'b1;
            if (pass_cnt_d == num_pass_q) begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        // One idle cycle so the final accumulate lands before done.
        if (comp_valid || psum_valid) begin
          err_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_pass_q  <= '0;
      pass_cnt_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cacc_en_q   <= 1'b0;
      cacc_addr_q <= '0;
      acc_en_q    <= 1'b0;
      acc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      num_pass_q  <= num_pass_d;
      pass_cnt_q  <= pass_cnt_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cacc_en_q   <= cacc_en_d;
      cacc_addr_q <= cacc_addr_d;
      acc_en_q    <= acc_en_d;
      acc_addr_q  <= acc_addr_d;
    end
  end

  assign CACC_Wr_en   = cacc_en_q;
  assign CAcc_Wr_Addr = cacc_addr_q;
  assign ACC_Wr_en    = acc_en_q;
  assign Acc_Wr_Addr  = acc_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_acc_write_scheduler.sv
// Directed bench for acc_write_scheduler with write-address scoreboards.
module tb_acc_write_scheduler;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] num_pass;
  logic       comp_valid;
  logic       psum_valid;
  logic       CACC_Wr_en;
  logic [2:0] CAcc_Wr_Addr;
  logic       ACC_Wr_en;
  logic [2:0] Acc_Wr_Addr;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cacc[$];
  logic [31:0] exp_acc[$];
  logic        exp_done;

  acc_write_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_pass     (num_pass),
    .comp_valid   (comp_valid),
    .psum_valid   (psum_valid),
    .CACC_Wr_en   (CACC_Wr_en),
    .CAcc_Wr_Addr (CAcc_Wr_Addr),
    .ACC_Wr_en    (ACC_Wr_en),
    .Acc_Wr_Addr  (Acc_Wr_Addr),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: drive valids, then compare the registered outputs of that edge
  // against whatever the stimulus queued for it.
  task automatic tick(input logic c, input logic p);
    logic [31:0] e;
    comp_valid = c;
    psum_valid = p;
    @(posedge clk);
    #1;
    if (exp_cacc.size() > 0) begin
      e = exp_cacc.pop_front();
      chk("cacc_en", 32'(CACC_Wr_en), 32'd1);
      chk("cacc_addr", 32'(CAcc_Wr_Addr), e);
    end else begin
      chk("cacc_en_quiet", 32'(CACC_Wr_en), 32'd0);
    end
    if (exp_acc.size() > 0) begin
      e = exp_acc.pop_front();
      chk("acc_en", 32'(ACC_Wr_en), 32'd1);
      chk("acc_addr", 32'(Acc_Wr_Addr), e);
    end else begin
      chk("acc_en_quiet", 32'(ACC_Wr_en), 32'd0);
    end
    if (CACC_Wr_en && ACC_Wr_en)
      chk("addr_distinct", 32'(CAcc_Wr_Addr != Acc_Wr_Addr), 32'd1);
    chk("done", 32'(done), 32'(exp_done));
    exp_done = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] np);
    start    = 1'b1;
    num_pass = np;
    tick(1'b0, 1'b0);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic preload_all();
    for (int i = 0; i < 8; i++) begin
      exp_cacc.push_back(32'(i));
      tick(1'b1, 1'b0);
    end
  endtask

  task automatic accum(input int n);
    for (int i = 0; i < n; i++) begin
      exp_acc.push_back(32'(i % 8));
      tick(1'b0, 1'b1);
    end
  endtask

  task automatic drain();
    exp_done = 1'b1;
    tick(1'b0, 1'b0);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    num_pass   = 4'd0;
    comp_valid = 1'b0;
    psum_valid = 1'b0;
    exp_done   = 1'b0;

    // Reset state
    #3;
    chk("rst_cacc_en", 32'(CACC_Wr_en), 32'd0);
    chk("rst_acc_en", 32'(ACC_Wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    #9;
    rst_n = 1'b1;

    // 1: single pass, preload then accumulate
    do_start(4'd1);
    preload_all();
    accum(8);
    drain();
    chk("t1_err", 32'(err), 32'd0);

    // 2: three passes, addresses 0..7 three times, single done
    do_start(4'd3);
    preload_all();
    accum(24);
    drain();
    chk("t2_err", 32'(err), 32'd0);

    // 3: overlapped preload and accumulate, psum one row behind
    do_start(4'd1);
    exp_cacc.push_back(32'd0);
    tick(1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      exp_cacc.push_back(32'(i));
      exp_acc.push_back(32'(i - 1));
      tick(1'b1, 1'b1);
    end
    exp_acc.push_back(32'd7);
    tick(1'b0, 1'b1);
    drain();
    chk("t3_err", 32'(err), 32'd0);

    // 4: psum before any preload landed is rejected, err sticky
    do_start(4'd1);
    tick(1'b0, 1'b1);
    chk("t4_err_set", 32'(err), 32'd1);
    preload_all();
    accum(8);
    drain();
    chk("t4_err_held", 32'(err), 32'd1);

    // 5: async reset in ACCUM at acc_cnt=5, then a clean restart
    do_start(4'd1);
    chk("t5_err_cleared", 32'(err), 32'd0);
    preload_all();
    accum(5);
    rst_n = 1'b0;
    #1;
    chk("t5_cacc_en", 32'(CACC_Wr_en), 32'd0);
    chk("t5_acc_en", 32'(ACC_Wr_en), 32'd0);
    chk("t5_acc_addr", 32'(Acc_Wr_Addr), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_err", 32'(err), 32'd0);
    #1;
    rst_n = 1'b1;
    do_start(4'd1);
    preload_all();
    accum(8);
    drain();

    // 6: num_pass=0 acts as one pass; start while busy ignored
    do_start(4'd0);
    preload_all();
    start = 1'b1;
    tick(1'b0, 1'b0);
    start = 1'b0;
    chk("t6_busy_hold", 32'(busy), 32'd1);
    chk("t6_err", 32'(err), 32'd0);
    accum(8);
    drain();
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    chk("t6_idle_err", 32'(err), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
